// File: rtl/irq_ctrl_if.sv
// Bus bundle between the interrupt controller and its surroundings:
// peripheral request lines, mask write port, pipeline hazards and the fetch redirect.
interface irq_ctrl_if #(
    parameter int unsigned N_SRC = 4
);
    logic [N_SRC-1:0] irq_src;
    logic             en_we;
    logic [N_SRC-1:0] en_wdata;
    logic             stall;
    logic             flush;
    logic             branch;
    logic             ret_rti;
    logic             ret_rsi;
    logic             interrupt;
    logic [2:0]       irq_cause;
    logic             irq_active;
    logic [N_SRC-1:0] pending;
    logic [N_SRC-1:0] en_mask;

    modport master (
        output irq_src, en_we, en_wdata, stall, flush, branch, ret_rti, ret_rsi,
        input  interrupt, irq_cause, irq_active, pending, en_mask
    );

    modport slave (
        input  irq_src, en_we, en_wdata, stall, flush, branch, ret_rti, ret_rsi,
        output interrupt, irq_cause, irq_active, pending, en_mask
    );
endinterface

// File: rtl/irq_ctrl.sv
// Edge-triggered, non-nesting interrupt controller: latches rising edges, picks the
// lowest enabled pending source and issues it to fetch only on a hazard-free cycle.
module irq_ctrl #(
    parameter int unsigned N_SRC     = 4,
    parameter int unsigned DRAIN_CYC = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    irq_ctrl_if.slave    bus
);
    localparam int unsigned CW = 3;
    localparam int unsigned IW = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_ISSUE,
        S_SERVICE,
        S_DRAIN
    } state_e;

    state_e           state_q;
    logic [N_SRC-1:0] src_q;
    logic             armed_q;
    logic [N_SRC-1:0] pending_q;
    logic [N_SRC-1:0] pending_d;
    logic [N_SRC-1:0] en_mask_q;
    logic [CW-1:0]    drain_q;
    logic             interrupt_q;
    logic             irq_active_q;
    logic [IW-1:0]    irq_cause_q;

    logic [N_SRC-1:0] edges;
    logic [N_SRC-1:0] eligible;
    logic [N_SRC-1:0] clr;
    logic [IW-1:0]    sel_idx;
    logic             hazard;
    logic             issue_go;

    // armed_q suppresses the first sample after reset so a line held high through
    // reset is not mistaken for a fresh request.
    always_comb begin
        edges    = armed_q ? (bus.irq_src & ~src_q) : '0;
        eligible = pending_q & en_mask_q;
        sel_idx  = '0;
        for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
            if (eligible[i]) sel_idx = IW'(i);
        end
        hazard    = bus.stall | bus.flush | bus.branch;
        issue_go  = (state_q == S_WAIT) && (eligible != '0) && !hazard;
        clr       = issue_go ? (N_SRC'(1) << sel_idx) : '0;
        pending_d = (pending_q & ~clr) | edges;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            src_q        <= '0;
            armed_q      <= 1'b0;
            pending_q    <= '0;
            en_mask_q    <= '0;
            drain_q      <= '0;
            interrupt_q  <= 1'b0;
            irq_active_q <= 1'b0;
            irq_cause_q  <= '0;
        end else begin
            src_q       <= bus.irq_src;
            armed_q     <= 1'b1;
            pending_q   <= pending_d;
            interrupt_q <= 1'b0;
            if (bus.en_we) en_mask_q <= bus.en_wdata;

            case (state_q)
                S_IDLE: begin
                    if (eligible != '0) state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (eligible == '0) begin
                        state_q <= S_IDLE;
                    end else if (issue_go) begin
                        state_q      <= S_ISSUE;
                        interrupt_q  <= 1'b1;
                        irq_active_q <= 1'b1;
                        irq_cause_q  <= sel_idx;
                    end
                end
                S_ISSUE: begin
                    state_q <= S_SERVICE;
                end
                S_SERVICE: begin
                    if (bus.ret_rti || bus.ret_rsi) begin
                        state_q      <= S_DRAIN;
                        irq_active_q <= 1'b0;
                        drain_q      <= CW'(DRAIN_CYC);
                    end
                end
                S_DRAIN: begin
                    if (drain_q <= CW'(1)) begin
                        state_q <= S_IDLE;
                        drain_q <= '0;
                    end else begin
                        drain_q <= drain_q - CW'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.interrupt  = interrupt_q;
    assign bus.irq_active = irq_active_q;
    assign bus.irq_cause  = irq_cause_q;
    assign bus.pending    = pending_q;
    assign bus.en_mask    = en_mask_q;

endmodule
